// File: rtl/rsa_core_arbiter_if.sv
// Requester-side bundle for rsa_core_arbiter: two operand request channels and a
// shared response channel. Signal prefixes are from the arbiter's point of view.
//   i_req_valid/o_req_ready : per-requester operand handshake (bit k = requester k)
//   i_a0/i_e0/i_n0, i_a1/i_e1/i_n1 : base, exponent and modulus of each requester
//   o_resp_valid/i_resp_ready : per-requester result handshake
//   o_resp_data/o_resp_err  : shared result and watchdog error flag
interface rsa_core_arbiter_if #(
  parameter int unsigned WIDTH = 256
);
  logic [1:0]       i_req_valid;
  logic [1:0]       o_req_ready;
  logic [WIDTH-1:0] i_a0;
  logic [WIDTH-1:0] i_e0;
  logic [WIDTH-1:0] i_n0;
  logic [WIDTH-1:0] i_a1;
  logic [WIDTH-1:0] i_e1;
  logic [WIDTH-1:0] i_n1;
  logic [1:0]       o_resp_valid;
  logic [1:0]       i_resp_ready;
  logic [WIDTH-1:0] o_resp_data;
  logic             o_resp_err;

  // Arbiter side
  modport slave (
    input  i_req_valid, i_a0, i_e0, i_n0, i_a1, i_e1, i_n1, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_data, o_resp_err
  );

  // Requester side
  modport master (
    output i_req_valid, i_a0, i_e0, i_n0, i_a1, i_e1, i_n1, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err
  );
endinterface

// File: rtl/rsa_core_arbiter.sv
// Round-robin front end for a single modular-exponentiation core shared by two
// requesters. Latches the granted operand triple, pulses the core start, waits
// for the core to go busy and then idle again, and returns the result (or a
// watchdog error) to the granted requester.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   req_if (slave)   : request/response channels of both requesters
//   o_core_start     : one-cycle start pulse to the core
//   o_core_a/e/n     : registered operands to the core
//   i_core_result    : core result
//   i_core_finished  : core idle/finished level
//   o_busy           : an operation is in flight
module rsa_core_arbiter #(
  parameter int unsigned WIDTH          = 256,
  parameter int unsigned TIMEOUT_CYCLES = 70000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  rsa_core_arbiter_if.slave  req_if,
  output logic               o_core_start,
  output logic [WIDTH-1:0]   o_core_a,
  output logic [WIDTH-1:0]   o_core_e,
  output logic [WIDTH-1:0]   o_core_n,
  input  logic [WIDTH-1:0]   i_core_result,
  input  logic               i_core_finished,
  output logic               o_busy
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  state_e           state_q;
  logic             last_q;
  logic             g_q;
  logic             start_q;
  logic             busy_q;
  logic [1:0]       resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_err_q;
  logic [WIDTH-1:0] core_a_q;
  logic [WIDTH-1:0] core_e_q;
  logic [WIDTH-1:0] core_n_q;
  logic [TW-1:0]    timer_q;

  logic             gnt_vld;
  logic             gnt_idx;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    case (req_if.i_req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0;    end
      2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1;    end
      2'b11:   begin gnt_vld = 1'b1; gnt_idx = ~last_q; end
      default: ;
    endcase
  end

  // Ready is held low during reset so every output reads zero while i_rst_n is low
  assign req_if.o_req_ready = (i_rst_n && state_q == S_IDLE && gnt_vld)
                              ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // Sequencer, watchdog and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      g_q          <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      core_a_q     <= '0;
      core_e_q     <= '0;
      core_n_q     <= '0;
      timer_q      <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            g_q      <= gnt_idx;
            core_a_q <= gnt_idx ? req_if.i_a1 : req_if.i_a0;
            core_e_q <= gnt_idx ? req_if.i_e1 : req_if.i_e0;
            core_n_q <= gnt_idx ? req_if.i_n1 : req_if.i_n0;
            timer_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START, S_WAIT_BUSY, S_WAIT_DONE: begin
          // Expiry wins over any same-cycle start or finish
          if (timer_q == TMAX) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= g_q ? 2'b10 : 2'b01;
            state_q      <= S_RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
            if (state_q == S_START) begin
              if (i_core_finished) begin
                start_q <= 1'b1;
                timer_q <= '0;
                state_q <= S_WAIT_BUSY;
              end
            end else if (state_q == S_WAIT_BUSY) begin
              if (!i_core_finished) begin
                state_q <= S_WAIT_DONE;
              end
            end else if (i_core_finished) begin
              resp_data_q  <= i_core_result;
              resp_err_q   <= 1'b0;
              resp_valid_q <= g_q ? 2'b10 : 2'b01;
              state_q      <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (req_if.i_resp_ready[g_q]) begin
            last_q       <= g_q;
            resp_valid_q <= 2'b00;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_if.o_resp_valid = resp_valid_q;
  assign req_if.o_resp_data  = resp_data_q;
  assign req_if.o_resp_err   = resp_err_q;
  assign o_core_start        = start_q;
  assign o_core_a            = core_a_q;
  assign o_core_e            = core_e_q;
  assign o_core_n            = core_n_q;
  assign o_busy              = busy_q;
endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: stub exponentiation core, transaction-level
// reference model compared every cycle, plus directed scenarios.
module tb_rsa_core_arbiter;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 100;

  logic clk;
  logic rst_n;
  logic core_start;
  logic [W-1:0] core_a, core_e, core_n, core_result;
  logic core_finished;
  logic busy;

  int n_checks = 0;
  int n_err    = 0;
  int n_starts = 0;
  bit chk_en   = 0;

  // Stub core controls: 0 normal, 1 finished stuck high, 2 finished stuck low
  int mode    = 0;
  int lat_lo  = 3;
  int lat_hi  = 12;
  bit long_ok = 0;

  rsa_core_arbiter_if #(.WIDTH(W)) ifc ();

  rsa_core_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .req_if          (ifc.slave),
    .o_core_start    (core_start),
    .o_core_a        (core_a),
    .o_core_e        (core_e),
    .o_core_n        (core_n),
    .i_core_result   (core_result),
    .i_core_finished (core_finished),
    .o_busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
    longint unsigned r, b, m;
    m = 64'(n);
    r = 1 % m;
    b = 64'(a) % m;
    for (int i = 0; i < int'(W); i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return W'(r);
  endfunction

  // Which requester is served: -1 none, else index
  function automatic int pick(input logic [1:0] v, input bit last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) return last ? 0 : 1;
    return -1;
  endfunction

  // Stub core: idle with finished high; goes busy after a start, finishes later
  logic         fin_q;
  int           cnt_q;
  logic [W-1:0] res_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_q <= 1'b1;
      cnt_q <= 0;
      res_q <= '0;
    end else if (core_start && fin_q) begin
      fin_q <= 1'b0;
      cnt_q <= (long_ok && $urandom_range(0, 9) == 0) ? int'($urandom_range(100, 140))
                                                      : int'($urandom_range(lat_lo, lat_hi));
      res_q <= modexp(core_a, core_e, core_n);
    end else if (!fin_q && cnt_q > 0) begin
      cnt_q <= cnt_q - 1;
    end else if (!fin_q) begin
      fin_q <= 1'b1;
    end
  end
  assign core_finished = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : fin_q;
  assign core_result   = res_q;

  // Reference model: one operation record, advanced once per clock
  bit           m_active, m_started, m_seen_busy, m_resp, m_start, m_err, m_g, m_last;
  logic [W-1:0] m_a, m_e, m_n, m_data;
  int           m_timer;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 0; m_started = 0; m_seen_busy = 0; m_resp = 0; m_start = 0;
        m_err = 0; m_g = 0; m_last = 1; m_a = '0; m_e = '0; m_n = '0; m_data = '0;
        m_timer = 0;
      end else begin
        m_start = 0;
        if (!m_active) begin
          int p;
          p = pick(ifc.i_req_valid, m_last);
          if (p >= 0) begin
            m_active = 1; m_g = (p == 1); m_started = 0; m_seen_busy = 0; m_timer = 0;
            m_a = m_g ? ifc.i_a1 : ifc.i_a0;
            m_e = m_g ? ifc.i_e1 : ifc.i_e0;
            m_n = m_g ? ifc.i_n1 : ifc.i_n0;
          end
        end else if (m_resp) begin
          if (ifc.i_resp_ready[m_g]) begin
            m_resp = 0; m_active = 0; m_last = m_g;
          end
        end else if (m_timer == int'(TO)) begin
          m_resp = 1; m_data = '0; m_err = 1;
        end else if (!m_started) begin
          if (core_finished) begin m_start = 1; m_started = 1; m_timer = 0; end
          else m_timer++;
        end else if (!m_seen_busy) begin
          if (!core_finished) m_seen_busy = 1;
          m_timer++;
        end else if (core_finished) begin
          m_resp = 1; m_data = modexp(m_a, m_e, m_n); m_err = 0;
        end else begin
          m_timer++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) n_starts++;
      if (chk_en) begin
        int p;
        logic [1:0] exp_rdy, exp_rv;
        p = pick(ifc.i_req_valid, m_last);
        exp_rdy = (!rst_n || m_active || p < 0) ? 2'b00 : (p == 1 ? 2'b10 : 2'b01);
        exp_rv  = !m_resp ? 2'b00 : (m_g ? 2'b10 : 2'b01);
        chk("cyc_busy",       64'(busy),             64'(m_active));
        chk("cyc_req_ready",  64'(ifc.o_req_ready),  64'(exp_rdy));
        chk("cyc_core_start", 64'(core_start),       64'(m_start));
        chk("cyc_core_a",     64'(core_a),           64'(m_a));
        chk("cyc_core_e",     64'(core_e),           64'(m_e));
        chk("cyc_core_n",     64'(core_n),           64'(m_n));
        chk("cyc_resp_valid", 64'(ifc.o_resp_valid), 64'(exp_rv));
        chk("cyc_resp_data",  64'(ifc.o_resp_data),  64'(m_data));
        chk("cyc_resp_err",   64'(ifc.o_resp_err),   64'(m_err));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_resp(input int maxc, output logic [1:0] v, output logic [W-1:0] d,
                           output logic er, output int cyc);
    cyc = 0;
    while (ifc.o_resp_valid == 2'b00 && cyc < maxc) begin tick(); cyc++; end
    v = ifc.o_resp_valid; d = ifc.o_resp_data; er = ifc.o_resp_err;
    if (v == 2'b00) begin
      n_checks++; n_err++;
      $display("FAIL resp_wait at %0t: got no response expected one within %0d cycles", $time, maxc);
    end
  endtask

  task automatic wait_start(input int maxc, output int cyc);
    cyc = 0;
    while (core_start !== 1'b1 && cyc < maxc) begin tick(); cyc++; end
    if (core_start !== 1'b1) begin
      n_checks++; n_err++;
      $display("FAIL start_wait at %0t: got no start pulse expected one within %0d cycles", $time, maxc);
    end
  endtask

  task automatic ack(input logic [1:0] v);
    ifc.i_resp_ready = v;
    tick();
    ifc.i_resp_ready = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at %0t: got no finish expected finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] v;
    logic [W-1:0] d;
    logic er;
    int c, c2, s0;
    rst_n = 1'b0;
    ifc.i_req_valid = 2'b00; ifc.i_resp_ready = 2'b00;
    ifc.i_a0 = '0; ifc.i_e0 = '0; ifc.i_n0 = '0;
    ifc.i_a1 = '0; ifc.i_e1 = '0; ifc.i_n1 = '0;
    repeat (3) tick();
    chk_en = 1;

    // Hand-computed values pinning the reference
    chk("ref_modexp_3_5_7",     64'(modexp(32'd3, 32'd5, 32'd7)),     64'd5);
    chk("ref_modexp_2_10_1000", 64'(modexp(32'd2, 32'd10, 32'd1000)), 64'd24);
    chk("ref_pick_tie_after_reset", 64'(pick(2'b11, 1'b1)), 64'd0);
    chk("ref_pick_tie_after_0",     64'(pick(2'b11, 1'b0)), 64'd1);

    // Reset state
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_rv",    64'(ifc.o_resp_valid), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_err",   64'(ifc.o_resp_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request; requester inputs change right after acceptance
    s0 = n_starts;
    ifc.i_a0 = 32'd3; ifc.i_e0 = 32'd5; ifc.i_n0 = 32'd7; ifc.i_req_valid = 2'b01;
    tick();
    ifc.i_req_valid = 2'b00; ifc.i_a0 = 32'd9; ifc.i_e0 = 32'd2; ifc.i_n0 = 32'd100;
    wait_resp(200, v, d, er, c);
    chk("t1_valid", 64'(v), 64'h1);
    chk("t1_data",  64'(d), 64'd5);
    chk("t1_err",   64'(er), 64'd0);
    chk("t1_core_a_held", 64'(core_a), 64'd3);
    chk("t1_one_start", 64'(n_starts - s0), 64'd1);

    // Response held off for 20 cycles with both requesters waiting
    s0 = n_starts;
    ifc.i_req_valid = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", 64'(ifc.o_resp_valid), 64'h1);
      chk("hold_data",  64'(ifc.o_resp_data), 64'd5);
      chk("hold_ready", 64'(ifc.o_req_ready), 64'h0);
    end
    chk("hold_no_start", 64'(n_starts - s0), 64'd0);
    ack(2'b10);
    chk("wrong_ready_ignored", 64'(ifc.o_resp_valid), 64'h1);
    ack(2'b01);
    ifc.i_req_valid = 2'b00;

    // Both valid from reset: alternating grants 0,1,0,1
    do_reset();
    ifc.i_a0 = 32'd2; ifc.i_e0 = 32'd10; ifc.i_n0 = 32'd1000;
    ifc.i_a1 = 32'd3; ifc.i_e1 = 32'd5;  ifc.i_n1 = 32'd7;
    ifc.i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ev;
      logic [W-1:0] ed;
      ev = (k % 2 == 0) ? 2'b01 : 2'b10;
      ed = (k % 2 == 0) ? 32'd24 : 32'd5;
      wait_resp(200, v, d, er, c);
      chk("rr_grant", 64'(v), 64'(ev));
      chk("rr_data",  64'(d), 64'(ed));
      ack(v);
      if (k == 3) ifc.i_req_valid = 2'b00;
    end

    // Finished stuck high: start pulse, then watchdog error
    mode = 1;
    ifc.i_a0 = 32'd4; ifc.i_e0 = 32'd3; ifc.i_n0 = 32'd11; ifc.i_req_valid = 2'b01;
    tick();
    ifc.i_req_valid = 2'b00;
    wait_start(20, c);
    wait_resp(300, v, d, er, c2);
    chk("to1_cycles", 64'(c2), 64'd101);
    chk("to1_valid",  64'(v), 64'h1);
    chk("to1_err",    64'(er), 64'd1);
    chk("to1_data",   64'(d), 64'd0);
    ack(v);

    // Finished stuck low: no start pulse, watchdog error
    mode = 2;
    s0 = n_starts;
    ifc.i_req_valid = 2'b01;
    tick();
    ifc.i_req_valid = 2'b00;
    wait_resp(300, v, d, er, c2);
    chk("to0_cycles",   64'(c2), 64'd101);
    chk("to0_err",      64'(er), 64'd1);
    chk("to0_data",     64'(d), 64'd0);
    chk("to0_no_start", 64'(n_starts - s0), 64'd0);
    ack(v);
    mode = 0;

    // Asynchronous reset while waiting for the core to finish
    lat_lo = 40; lat_hi = 40;
    ifc.i_a0 = 32'd5; ifc.i_e0 = 32'd3; ifc.i_n0 = 32'd13; ifc.i_req_valid = 2'b01;
    tick();
    ifc.i_req_valid = 2'b00;
    wait_start(20, c);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(busy), 64'd0);
    chk("arst_rv",     64'(ifc.o_resp_valid), 64'd0);
    chk("arst_start",  64'(core_start), 64'd0);
    chk("arst_core_a", 64'(core_a), 64'd0);
    chk("arst_err",    64'(ifc.o_resp_err), 64'd0);
    chk("arst_data",   64'(ifc.o_resp_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    lat_lo = 3; lat_hi = 12;
    tick();
    ifc.i_a1 = 32'd2; ifc.i_e1 = 32'd10; ifc.i_n1 = 32'd1000; ifc.i_req_valid = 2'b10;
    tick();
    ifc.i_req_valid = 2'b00;
    wait_resp(200, v, d, er, c);
    chk("post_rst_valid", 64'(v), 64'h2);
    chk("post_rst_data",  64'(d), 64'd24);
    chk("post_rst_err",   64'(er), 64'd0);
    ack(v);

    // Randomized traffic, including occasional core latencies beyond the watchdog
    long_ok = 1; lat_lo = 1; lat_hi = 30;
    for (int i = 0; i < 4000; i++) begin
      tick();
      ifc.i_req_valid  = 2'($urandom_range(0, 3));
      ifc.i_resp_ready = 2'($urandom_range(0, 3));
      ifc.i_a0 = W'($urandom_range(0, 999)); ifc.i_e0 = W'($urandom_range(0, 255));
      ifc.i_n0 = W'($urandom_range(1, 1000));
      ifc.i_a1 = W'($urandom_range(0, 999)); ifc.i_e1 = W'($urandom_range(0, 255));
      ifc.i_n1 = W'($urandom_range(1, 1000));
    end
    ifc.i_req_valid = 2'b00; ifc.i_resp_ready = 2'b11;
    c = 0;
    while (busy && c < 400) begin tick(); c++; end
    chk("drain_idle", 64'(busy), 64'd0);
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
